// File: rtl/dual_port_pio.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_pio
// Purpose  : Dual-port general-purpose I/O register block. Two independent
//            memory-mapped slave ports (A, B) share one register file holding
//            output data, direction, atomic set/clear, synchronised input
//            sampling, rising-edge capture and a level interrupt.
// Ports    : clk, reset (async, active high)
//            address_x[3:0], writedata_x[31:0], write_x, readdata_x[31:0]
//              for x = a, b (readdata is registered, one-cycle latency)
//            gpio_in[DATA_W-1:0]  asynchronous pin inputs
//            gpio_out / gpio_oe   OUT and DIR registers
//            irq                  |(EDGE_CAP & IRQ_MASK)
// Options  : define PIO_EDGE_IRQ_EN to build the history flop, EDGE_CAP,
//            IRQ_MASK and irq logic; otherwise those addresses read 0 and
//            irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_pio #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] OUT_RESET = '0,
    parameter logic [DATA_W-1:0] DIR_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        address_a,
    input  logic [31:0]       writedata_a,
    input  logic              write_a,
    output logic [31:0]       readdata_a,
    input  logic [3:0]        address_b,
    input  logic [31:0]       writedata_b,
    input  logic              write_b,
    output logic [31:0]       readdata_b,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out,
    output logic [DATA_W-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [3:0] c_ADDR_OUT  = 4'd0;
    localparam logic [3:0] c_ADDR_IN   = 4'd1;
    localparam logic [3:0] c_ADDR_DIR  = 4'd2;
    localparam logic [3:0] c_ADDR_MASK = 4'd3;
    localparam logic [3:0] c_ADDR_CAP  = 4'd4;

    localparam logic [3:0] c_ADDR_SET  = 4'd5;
    localparam logic [3:0] c_ADDR_CLR  = 4'd6;

    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] s1_q, s2_q;
    logic [31:0]       readdata_a_q, readdata_a_d;
    logic [31:0]       readdata_b_q, readdata_b_d;

    logic [DATA_W-1:0] w_wd_a, w_wd_b;
    logic [DATA_W-1:0] w_set, w_clr;
    logic [DATA_W-1:0] w_mask_rd, w_cap_rd;

    assign w_wd_a = writedata_a[DATA_W-1:0];
    assign w_wd_b = writedata_b[DATA_W-1:0];

    // Set/clear strobes from both ports merge; clear dominates when applied.
    assign w_set = ({DATA_W{write_a && (address_a == c_ADDR_SET)}} & w_wd_a)
                 | ({DATA_W{write_b && (address_b == c_ADDR_SET)}} & w_wd_b);
    assign w_clr = ({DATA_W{write_a && (address_a == c_ADDR_CLR)}} & w_wd_a)
                 | ({DATA_W{write_b && (address_b == c_ADDR_CLR)}} & w_wd_b);

    // A direct OUT write (port A first) overrides any set/clear this cycle.
    always_comb begin
        out_d = (out_q | w_set) & ~w_clr;
        if (write_a && (address_a == c_ADDR_OUT)) begin
            out_d = w_wd_a;
        end else if (write_b && (address_b == c_ADDR_OUT)) begin
            out_d = w_wd_b;
        end
    end

    always_comb begin
        dir_d = dir_q;
        if (write_a && (address_a == c_ADDR_DIR)) begin
            dir_d = w_wd_a;
        end else if (write_b && (address_b == c_ADDR_DIR)) begin
            dir_d = w_wd_b;
        end
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [DATA_W-1:0] s3_q;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] w_w1c, w_new_edge;

    assign w_new_edge = s2_q & ~s3_q;
    assign w_w1c = ({DATA_W{write_a && (address_a == c_ADDR_CAP)}} & w_wd_a)
                 | ({DATA_W{write_b && (address_b == c_ADDR_CAP)}} & w_wd_b);

    always_comb begin
        mask_d = mask_q;
        if (write_a && (address_a == c_ADDR_MASK)) begin
            mask_d = w_wd_a;
        end else if (write_b && (address_b == c_ADDR_MASK)) begin
            mask_d = w_wd_b;
        end
    end

    // New edges are OR'ed in after the clear so a coincident edge is kept.
    always_comb begin
        cap_d = (cap_q & ~w_w1c) | w_new_edge;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_q   <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            s3_q   <= s2_q;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    assign w_mask_rd = mask_q;
    assign w_cap_rd  = cap_q;
    assign irq       = |(cap_q & mask_q);
`else
    assign w_mask_rd = '0;
    assign w_cap_rd  = '0;
    assign irq       = 1'b0;
`endif

    function automatic logic [31:0] rd_mux(
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] v_out,
        input logic [DATA_W-1:0] v_in,
        input logic [DATA_W-1:0] v_dir,
        input logic [DATA_W-1:0] v_mask,
        input logic [DATA_W-1:0] v_cap
    );
        logic [31:0] v;
        v = '0;
        case (addr)
            c_ADDR_OUT:  v[DATA_W-1:0] = v_out;
            c_ADDR_IN:   v[DATA_W-1:0] = v_in;
            c_ADDR_DIR:  v[DATA_W-1:0] = v_dir;
            c_ADDR_MASK: v[DATA_W-1:0] = v_mask;
            c_ADDR_CAP:  v[DATA_W-1:0] = v_cap;
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Reads sample current register contents, so a read coincident with a
    // write to the same register returns the pre-write value.
    always_comb begin
        readdata_a_d = rd_mux(address_a, out_q, s2_q, dir_q, w_mask_rd, w_cap_rd);
        readdata_b_d = rd_mux(address_b, out_q, s2_q, dir_q, w_mask_rd, w_cap_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= OUT_RESET;
            dir_q        <= DIR_RESET;
            s1_q         <= '0;
            s2_q         <= '0;
            readdata_a_q <= '0;
            readdata_b_q <= '0;
        end else begin
            out_q        <= out_d;
            dir_q        <= dir_d;
            s1_q         <= gpio_in;
            s2_q         <= s1_q;
            readdata_a_q <= readdata_a_d;
            readdata_b_q <= readdata_b_d;
        end
    end

    assign readdata_a = readdata_a_q;
    assign readdata_b = readdata_b_q;
    assign gpio_out   = out_q;
    assign gpio_oe    = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_pio
// Purpose  : Directed self-checking bench for dual_port_pio (DATA_W=32,
//            OUT_RESET=A5A5_0000). Edge/irq scenarios are built when
//            PIO_EDGE_IRQ_EN is defined, the disabled-feature scenario
//            otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address_a, address_b;
    logic [31:0] writedata_a, writedata_b;
    logic        write_a, write_b;
    logic [31:0] readdata_a, readdata_b;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dual_port_pio #(
        .DATA_W    (32),
        .OUT_RESET (32'hA5A5_0000),
        .DIR_RESET (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address_a   (address_a),
        .writedata_a (writedata_a),
        .write_a     (write_a),
        .readdata_a  (readdata_a),
        .address_b   (address_b),
        .writedata_b (writedata_b),
        .write_b     (write_b),
        .readdata_b  (readdata_b),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    // Drive both ports at the falling edge, then return 1 ns after the
    // following rising edge so outputs are sampled away from the clock.
    task automatic step(input logic wa, input logic [3:0] aa, input logic [31:0] da,
                        input logic wb, input logic [3:0] ab, input logic [31:0] db);
        @(negedge clk);
        write_a = wa; address_a = aa; writedata_a = da;
        write_b = wb; address_b = ab; writedata_b = db;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        write_a = 1'b0; address_a = 4'd0; writedata_a = '0;
        write_b = 1'b0; address_b = 4'd0; writedata_b = '0;
        gpio_in = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (gpio_out !== 32'hA5A5_0000) begin miscompares++; $display("FAIL reset_gpio_out got %h want %h", gpio_out, 32'hA5A5_0000); end
        vectors++; if (gpio_oe !== 32'h0) begin miscompares++; $display("FAIL reset_gpio_oe got %h want %h", gpio_oe, 32'h0); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
        vectors++; if (readdata_a !== 32'h0) begin miscompares++; $display("FAIL reset_readdata_a got %h want 0", readdata_a); end
        vectors++; if (readdata_b !== 32'h0) begin miscompares++; $display("FAIL reset_readdata_b got %h want 0", readdata_b); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_collision;
        step(1'b1, 4'd0, 32'h1234_5678, 1'b1, 4'd0, 32'hDEAD_BEEF);
        vectors++; if (gpio_out !== 32'h1234_5678) begin miscompares++; $display("FAIL collision_out got %h want %h", gpio_out, 32'h1234_5678); end
        vectors++; if (readdata_b !== 32'hA5A5_0000) begin miscompares++; $display("FAIL collision_old_read got %h want %h", readdata_b, 32'hA5A5_0000); end
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        vectors++; if (readdata_b !== 32'h1234_5678) begin miscompares++; $display("FAIL collision_new_read got %h want %h", readdata_b, 32'h1234_5678); end
    endtask

    task automatic test_diff_regs;
        step(1'b1, 4'd2, 32'h0000_FFFF, 1'b1, 4'd0, 32'h0000_0F0F);
        vectors++; if (gpio_oe !== 32'h0000_FFFF) begin miscompares++; $display("FAIL diff_dir got %h want %h", gpio_oe, 32'h0000_FFFF); end
        vectors++; if (gpio_out !== 32'h0000_0F0F) begin miscompares++; $display("FAIL diff_out got %h want %h", gpio_out, 32'h0000_0F0F); end
        step(1'b0, 4'd2, 32'h0, 1'b0, 4'd0, 32'h0);
        vectors++; if (readdata_a !== 32'h0000_FFFF) begin miscompares++; $display("FAIL diff_dir_read got %h want %h", readdata_a, 32'h0000_FFFF); end
    endtask

    task automatic test_set_clear;
        step(1'b1, 4'd0, 32'h0000_00F0, 1'b0, 4'd0, 32'h0);
        step(1'b1, 4'd5, 32'h0000_000F, 1'b1, 4'd6, 32'h0000_0011);
        vectors++; if (gpio_out !== 32'h0000_00EE) begin miscompares++; $display("FAIL setclr_out got %h want %h", gpio_out, 32'h0000_00EE); end
        vectors++; if (readdata_a !== 32'h0) begin miscompares++; $display("FAIL setclr_read_set_addr got %h want 0", readdata_a); end
        step(1'b1, 4'd0, 32'h0000_0100, 1'b1, 4'd5, 32'h0000_0001);
        vectors++; if (gpio_out !== 32'h0000_0100) begin miscompares++; $display("FAIL setclr_direct_override got %h want %h", gpio_out, 32'h0000_0100); end
    endtask

    task automatic test_in_path;
        step(1'b0, 4'd1, 32'h0, 1'b0, 4'd0, 32'h0);
        gpio_in = 32'h0000_0055;
        step(1'b1, 4'd1, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'h0); // edge k; IN write ignored
        step(1'b0, 4'd1, 32'h0, 1'b0, 4'd0, 32'h0);         // edge k+1
        vectors++; if (readdata_a !== 32'h0) begin miscompares++; $display("FAIL in_early got %h want 0", readdata_a); end
        step(1'b0, 4'd1, 32'h0, 1'b0, 4'd0, 32'h0);         // edge k+2
        vectors++; if (readdata_a !== 32'h0000_0055) begin miscompares++; $display("FAIL in_sync got %h want %h", readdata_a, 32'h0000_0055); end
    endtask

`ifdef PIO_EDGE_IRQ_EN
    task automatic test_edge_capture;
        gpio_in = '0;
        repeat (3) step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step(1'b1, 4'd4, 32'hFFFF_FFFF, 1'b1, 4'd3, 32'h0000_0001);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_irq_idle got %b want 0", irq); end
        gpio_in = 32'h0000_0001;
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);         // k
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);         // k+1
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_irq_early got %b want 0", irq); end
        step(1'b0, 4'd4, 32'h0, 1'b0, 4'd3, 32'h0);         // k+2
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL edge_irq_set got %b want 1", irq); end
        step(1'b0, 4'd4, 32'h0, 1'b0, 4'd3, 32'h0);
        vectors++; if (readdata_a !== 32'h1) begin miscompares++; $display("FAIL edge_cap_read got %h want 1", readdata_a); end
        vectors++; if (readdata_b !== 32'h1) begin miscompares++; $display("FAIL edge_mask_read got %h want 1", readdata_b); end
        step(1'b1, 4'd4, 32'h0000_0001, 1'b0, 4'd0, 32'h0);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_irq_clear got %b want 0", irq); end
    endtask

    task automatic test_edge_during_clear;
        gpio_in = 32'h0000_0009;
        repeat (3) step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        gpio_in = 32'h0000_0001;
        repeat (3) step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        gpio_in = 32'h0000_0009;
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);         // k
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);         // k+1
        step(1'b1, 4'd4, 32'h0000_0008, 1'b0, 4'd0, 32'h0); // k+2 with clear
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd4, 32'h0);
        vectors++; if (readdata_b !== 32'h0000_0008) begin miscompares++; $display("FAIL edge_clear_race got %h want %h", readdata_b, 32'h0000_0008); end
        step(1'b1, 4'd4, 32'h0000_0008, 1'b0, 4'd4, 32'h0);
        step(1'b0, 4'd0, 32'h0, 1'b0, 4'd4, 32'h0);
        vectors++; if (readdata_b !== 32'h0) begin miscompares++; $display("FAIL edge_clear_plain got %h want 0", readdata_b); end
    endtask
`else
    task automatic test_macro_off;
        gpio_in = 32'h0000_00FF;
        step(1'b1, 4'd3, 32'hFFFF_FFFF, 1'b1, 4'd4, 32'hFFFF_FFFF);
        repeat (3) step(1'b0, 4'd3, 32'h0, 1'b0, 4'd4, 32'h0);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL off_irq got %b want 0", irq); end
        vectors++; if (readdata_b !== 32'h0) begin miscompares++; $display("FAIL off_cap_read got %h want 0", readdata_b); end
        vectors++; if (readdata_a !== 32'h0) begin miscompares++; $display("FAIL off_mask_read got %h want 0", readdata_a); end
        step(1'b0, 4'd1, 32'h0, 1'b0, 4'd1, 32'h0);
        vectors++; if (readdata_b !== 32'h0000_00FF) begin miscompares++; $display("FAIL off_in_read got %h want %h", readdata_b, 32'h0000_00FF); end
    endtask
`endif

    initial begin
        test_reset();
        test_collision();
        test_diff_regs();
        test_set_clear();
        test_in_path();
`ifdef PIO_EDGE_IRQ_EN
        test_edge_capture();
        test_edge_during_clear();
`else
        test_macro_off();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
